// File: rtl/ym3016_dac_if.sv
// Serial link and decoded-sample bundle between the YM2610 digital output and the YM3016 DAC model.
// FRAME_ERR exists only when YM3016_FRAMECHK_EN is defined.
interface ym3016_dac_if;
    logic        PHI_S;
    logic        SH1;
    logic        SH2;
    logic        OP0;
    logic [15:0] OUT_L;
    logic [15:0] OUT_R;
    logic        VALID_L;
    logic        VALID_R;
`ifdef YM3016_FRAMECHK_EN
    logic        FRAME_ERR;

    modport master (
        output PHI_S, SH1, SH2, OP0,
        input  OUT_L, OUT_R, VALID_L, VALID_R, FRAME_ERR
    );

    modport slave (
        input  PHI_S, SH1, SH2, OP0,
        output OUT_L, OUT_R, VALID_L, VALID_R, FRAME_ERR
    );
`else
    modport master (
        output PHI_S, SH1, SH2, OP0,
        input  OUT_L, OUT_R, VALID_L, VALID_R
    );

    modport slave (
        input  PHI_S, SH1, SH2, OP0,
        output OUT_L, OUT_R, VALID_L, VALID_R
    );
`endif
endinterface

// File: rtl/ym3016_dac.sv
// YM3016 floating-point serial DAC model: deserialises OP0 framed by SH1/SH2 and decodes to signed 16-bit PCM.
// Optional framing check (BITCNT, sticky FRAME_ERR) is built when YM3016_FRAMECHK_EN is defined.
module ym3016_dac #(
    parameter int SYNC_STAGES = 2
) (
    input  logic         PHI_M,
    input  logic         nRESET,
    ym3016_dac_if.slave  dac
);

    // Bit order in each sync stage: {PHI_S, SH2, SH1, OP0}
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0]  pins_s;
    logic        phi_s_s;
    logic        sh1_s;
    logic        sh2_s;
    logic        op0_s;
    logic        phi_prev;
    logic        bit_ev;
    logic        fe_l;
    logic        fe_r;

    logic [15:0] sr;
    logic [1:0]  sh_prev;
    logic [12:0] w_l;
    logic [12:0] w_r;
    logic        pend_l;
    logic        pend_r;
    logic [15:0] out_l;
    logic [15:0] out_r;
    logic        valid_l;
    logic        valid_r;

    assign pins_s = sync_q[SYNC_STAGES-1];
    assign {phi_s_s, sh2_s, sh1_s, op0_s} = pins_s;

    assign bit_ev = phi_s_s & ~phi_prev;
    assign fe_l   = bit_ev & sh_prev[0] & ~sh1_s;
    assign fe_r   = bit_ev & sh_prev[1] & ~sh2_s;

    // w holds {E[2:0], M[9:0]}; the offset-binary mantissa becomes two's complement by flipping its MSB.
    function automatic logic [15:0] decode(input logic [12:0] w);
        logic [2:0]  e;
        logic [15:0] s;
        e = w[12:10];
        s = {{7{~w[9]}}, w[8:0]};
        return (e == 3'd0) ? 16'h0000 : (s << (e - 3'd1));
    endfunction

    always_ff @(posedge PHI_M or negedge nRESET) begin
        if (!nRESET) begin
            sync_q   <= '0;
            phi_prev <= 1'b0;
        end else begin
            sync_q[0] <= {dac.PHI_S, dac.SH2, dac.SH1, dac.OP0};
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            phi_prev <= phi_s_s;
        end
    end

    // Frame end captures SR as it stood before this bit's shift.
    always_ff @(posedge PHI_M or negedge nRESET) begin
        if (!nRESET) begin
            sr      <= '0;
            sh_prev <= '0;
            w_l     <= '0;
            w_r     <= '0;
            pend_l  <= 1'b0;
            pend_r  <= 1'b0;
        end else begin
            pend_l <= fe_l;
            pend_r <= fe_r;
            if (fe_l)
                w_l <= sr[15:3];
            if (fe_r)
                w_r <= sr[15:3];
            if (bit_ev) begin
                sr      <= {op0_s, sr[15:1]};
                sh_prev <= {sh2_s, sh1_s};
            end
        end
    end

    always_ff @(posedge PHI_M or negedge nRESET) begin
        if (!nRESET) begin
            out_l   <= '0;
            out_r   <= '0;
            valid_l <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            valid_l <= pend_l;
            valid_r <= pend_r;
            if (pend_l)
                out_l <= decode(w_l);
            if (pend_r)
                out_r <= decode(w_r);
        end
    end

    assign dac.OUT_L   = out_l;
    assign dac.OUT_R   = out_r;
    assign dac.VALID_L = valid_l;
    assign dac.VALID_R = valid_r;

`ifdef YM3016_FRAMECHK_EN
    logic [4:0] bitcnt;
    logic [4:0] bitcnt_inc;
    logic       first_seen;
    logic       frame_err_q;

    // bitcnt_inc is the bit count including the current bit; a frame end restarts the count.
    assign bitcnt_inc = (bitcnt == 5'd31) ? 5'd31 : bitcnt + 5'd1;

    always_ff @(posedge PHI_M or negedge nRESET) begin
        if (!nRESET) begin
            bitcnt      <= '0;
            first_seen  <= 1'b0;
            frame_err_q <= 1'b0;
        end else if (bit_ev) begin
            if (fe_l || fe_r) begin
                bitcnt     <= '0;
                first_seen <= 1'b1;
                if (first_seen && (bitcnt_inc != 5'd16))
                    frame_err_q <= 1'b1;
            end else begin
                bitcnt <= bitcnt_inc;
            end
        end
    end

    assign dac.FRAME_ERR = frame_err_q;
`endif

endmodule
